writeback_unit: RTL and testbench
=================================

# writeback_unit

Write-back stage that drives the register file's write port (`writeEnable`, `writeAddr`, `writeData`) from execute-stage results. Results arrive on a valid/ready handshake and are buffered in a small FIFO. They are retired to the register file at one write per cycle when the port is free. While a result is queued or in flight, the block forwards its value for the two operand read addresses, so decode never reads a stale register.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2
- `DATA_W`, 32: result/register data width
- `ADDR_W`, 3: register address width (8 registers)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `inValid`  in  1  execute result valid
- `inReady`  out  1  unit can accept a result this cycle
- `inAddr`  in  ADDR_W  destination register
- `inData`  in  DATA_W  result value
- `portBusy`  in  1  register-file write port taken by another writer; no retire this cycle
- `flush`  in  1  synchronous discard of all queued results
- `writeEnable`  out  1  register-file write strobe (registered)
- `writeAddr`  out  ADDR_W  register-file write address (registered)
- `writeData`  out  DATA_W  register-file write data (registered)
- `readAddrA`, `readAddrB`  in  ADDR_W  operand addresses, same as the register-file read ports
- `fwdHitA`, `fwdHitB`  out  1  a pending write targets that address
- `fwdDataA`, `fwdDataB`  out  DATA_W  newest pending value for that address
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy
- `busy`  out  1  `count != 0` or `writeEnable`

## Operation
- **Push**: occurs on an edge where `inValid && inReady`; the entry {`inAddr`, `inData`} is written at the tail.
- **inReady**: equals `!rst && count < DEPTH`. It depends only on occupancy; a same-cycle pop does not free a slot for a push.
- **Pop**: occurs on an edge where `count != 0 && !portBusy && !flush`. The head is loaded into the output register and `writeEnable` goes to 1 next cycle.
- **writeEnable**: if no pop occurs on an edge, `writeEnable` becomes 0 on that edge. `writeAddr` and `writeData` hold their last values.
- **Simultaneous push and pop**: both occur, and `count` is unchanged.
- **Pointers**: read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` is tracked separately: +1 on push, −1 on pop, unchanged on both or neither.
- **flush**: on the edge, `count` becomes 0, pointers reset, `writeEnable` becomes 0, and there is no push or pop. A write already asserted during the flush cycle completes at that edge, since the register file samples it.
- **Forwarding (per read port, combinational)**:
  - Candidates are valid FIFO entries plus the output register when `writeEnable` = 1.
  - Priority is newest FIFO entry (nearest tail) first, then older entries, then the output register.
  - `fwdHit` = 0 when nothing matches, and `fwdData` is then don't-care (drive 0).
  - A result being pushed in the current cycle is not forwarded.
- **Retirement**: writes retire in strict push order. Multiple pending writes to one register are all retired; none is coalesced.

## Timing
- **Reset values**:
  - `writeEnable`=0, `writeAddr`=0, `writeData`=0, `count`=0, `busy`=0, `fwdHitA/B`=0.
  - `inReady`=0 while `rst` is high, and 1 in the first cycle after release.
- **Latency**: a push at edge N with the FIFO empty and `portBusy`=0 pops at edge N+1. `writeEnable` is high during cycle N+1→N+2, and the register file captures the value at edge N+2.
- **Throughput**: one retire per cycle. While `portBusy` stays high, the FIFO fills and `inReady` drops once `count` = DEPTH.
- **Forwarding**: `fwdHit` is visible from the cycle after the push edge up to and including the `writeEnable` cycle. After edge N+2 the register file itself supplies the value.
- **Reset mid-operation**: all entries are lost immediately (asynchronous) and outputs take their reset values. No partial write is emitted after `rst` rises.

## Test plan
- **Single write**: reset, push {3, 0xDEADBEEF} at edge 1, `portBusy`=0 → `writeEnable`=1, `writeAddr`=3, `writeData`=0xDEADBEEF in cycle 2 only; `fwdHitA`=1 for `readAddrA`=3 during cycles 1–2, 0 from cycle 3.
- **Fill under stall**: `portBusy`=1, push 5 results to regs 0..4 → first 4 accepted, `inReady`=0 with `count`=4. Release `portBusy` → writes to regs 0,1,2,3 on 4 consecutive cycles; the 5th push is accepted on the first cycle `count`=3.
- **Forward priority**: `portBusy`=1, push {2,0x11} then {2,0x22} → `fwdDataA`=0x22 with `readAddrA`=2. After the first retire, still 0x22. After both retire, `fwdHitA`=0.
- **Simultaneous push/pop**: steady stream of pushes with `portBusy`=0 → `count` stays at 1 and one write per cycle emerges in push order, data 0x1..0x10.
- **Flush**: 3 entries queued, `writeEnable`=1 on {1,0xAA}, assert `flush` one cycle → the {1,0xAA} write completes; next cycle `writeEnable`=0, `count`=0, `busy`=0, and no further writes occur.
- **Async reset**: assert `rst` mid-cycle while `writeEnable`=1 with 2 entries queued → `writeEnable`, `count` and `fwdHit` go to 0 immediately without waiting for a clock edge; after release, `inReady`=1 and no stale write appears.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: buffers execute-stage results in a small FIFO and retires
// them to the register-file write port one per cycle, while forwarding the
// newest pending value for the two operand read addresses.
module writeback_unit #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [ADDR_W-1:0]          inAddr,
  input  logic [DATA_W-1:0]          inData,
  input  logic                       portBusy,
  input  logic                       flush,
  output logic                       writeEnable,
  output logic [ADDR_W-1:0]          writeAddr,
  output logic [DATA_W-1:0]          writeData,
  input  logic [ADDR_W-1:0]          readAddrA,
  input  logic [ADDR_W-1:0]          readAddrB,
  output logic                       fwdHitA,
  output logic                       fwdHitB,
  output logic [DATA_W-1:0]          fwdDataA,
  output logic [DATA_W-1:0]          fwdDataB,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage; kept in flops because every slot is searched for forwarding
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              in_ready;
  logic              push;
  logic              pop;

  // Slot index and validity of each entry ordered by age (0 = head/oldest)
  logic [PTR_W-1:0]  age_idx   [DEPTH];
  logic [DEPTH-1:0]  age_valid;

  logic              fwd_hit_a, fwd_hit_b;
  logic [DATA_W-1:0] fwd_data_a, fwd_data_b;

  // Ready depends on occupancy only; a same-cycle pop does not free a slot
  assign in_ready = !rst && (count_q < CNT_W'(DEPTH));
  assign push     = inValid && in_ready && !flush;
  assign pop      = (count_q != '0) && !portBusy && !flush;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_idx[gi]   = rd_ptr_q + PTR_W'(gi);
      assign age_valid[gi] = CNT_W'(gi) < count_q;
    end
  endgenerate

  // Next-state for pointers, occupancy and the registered write port
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we_d     = pop;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
    if (pop) begin
      waddr_d = mem_addr[rd_ptr_q];
      wdata_d = mem_data[rd_ptr_q];
    end
  end

  // State registers; reset drops all queued entries immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Tail write into FIFO storage; contents are only meaningful while counted
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= inAddr;
      mem_data[wr_ptr_q] <= inData;
    end
  end

  // Forwarding: output register lowest priority, then FIFO oldest to newest so the newest match wins
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    if (we_q && (waddr_q == readAddrA)) begin
      fwd_hit_a  = 1'b1;
      fwd_data_a = wdata_q;
    end
    if (we_q && (waddr_q == readAddrB)) begin
      fwd_hit_b  = 1'b1;
      fwd_data_b = wdata_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (age_valid[k] && (mem_addr[age_idx[k]] == readAddrA)) begin
        fwd_hit_a  = 1'b1;
        fwd_data_a = mem_data[age_idx[k]];
      end
      if (age_valid[k] && (mem_addr[age_idx[k]] == readAddrB)) begin
        fwd_hit_b  = 1'b1;
        fwd_data_b = mem_data[age_idx[k]];
      end
    end
  end

  assign inReady     = in_ready;
  assign writeEnable = we_q;
  assign writeAddr   = waddr_q;
  assign writeData   = wdata_q;
  assign fwdHitA     = fwd_hit_a;
  assign fwdHitB     = fwd_hit_b;
  assign fwdDataA    = fwd_data_a;
  assign fwdDataB    = fwd_data_b;
  assign count       = count_q;
  assign busy        = (count_q != '0) || we_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed testbench for writeback_unit with hand-computed expectations.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [2:0]  inAddr = '0;
  logic [31:0] inData = '0;
  logic        portBusy = 1'b0;
  logic        flush = 1'b0;
  logic        writeEnable;
  logic [2:0]  writeAddr;
  logic [31:0] writeData;
  logic [2:0]  readAddrA = '0;
  logic [2:0]  readAddrB = '0;
  logic        fwdHitA, fwdHitB;
  logic [31:0] fwdDataA, fwdDataB;
  logic [2:0]  count;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  writeback_unit #(.DEPTH(4), .DATA_W(32), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .inValid(inValid), .inReady(inReady), .inAddr(inAddr), .inData(inData),
    .portBusy(portBusy), .flush(flush),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .readAddrA(readAddrA), .readAddrB(readAddrB),
    .fwdHitA(fwdHitA), .fwdHitB(fwdHitB),
    .fwdDataA(fwdDataA), .fwdDataB(fwdDataB),
    .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stalled(input logic [2:0] a, input logic [31:0] d);
    inValid = 1'b1; inAddr = a; inData = d;
    cyc();
    inValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    #1;
    check_val("rst_inReady", 64'(inReady), 64'(0));
    check_val("rst_we", 64'(writeEnable), 64'(0));
    check_val("rst_waddr", 64'(writeAddr), 64'(0));
    check_val("rst_wdata", 64'(writeData), 64'(0));
    check_val("rst_count", 64'(count), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_fwdA", 64'(fwdHitA), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("rel_inReady", 64'(inReady), 64'(1));

    // ---------------- single write ----------------
    readAddrA = 3'd3; readAddrB = 3'd4;
    inValid = 1'b1; inAddr = 3'd3; inData = 32'hDEADBEEF;
    cyc();                                  // edge 1: push
    inValid = 1'b0;
    #1;
    check_val("sw1_count", 64'(count), 64'(1));
    check_val("sw1_we", 64'(writeEnable), 64'(0));
    check_val("sw1_fwdHitA", 64'(fwdHitA), 64'(1));
    check_val("sw1_fwdDataA", 64'(fwdDataA), 64'h0DEADBEEF);
    check_val("sw1_fwdHitB", 64'(fwdHitB), 64'(0));
    cyc();                                  // edge 2: pop
    check_val("sw2_we", 64'(writeEnable), 64'(1));
    check_val("sw2_waddr", 64'(writeAddr), 64'(3));
    check_val("sw2_wdata", 64'(writeData), 64'h0DEADBEEF);
    check_val("sw2_count", 64'(count), 64'(0));
    check_val("sw2_busy", 64'(busy), 64'(1));
    check_val("sw2_fwdHitA", 64'(fwdHitA), 64'(1));
    cyc();                                  // edge 3
    check_val("sw3_we", 64'(writeEnable), 64'(0));
    check_val("sw3_fwdHitA", 64'(fwdHitA), 64'(0));
    check_val("sw3_waddr_hold", 64'(writeAddr), 64'(3));
    check_val("sw3_busy", 64'(busy), 64'(0));

    // ---------------- fill under stall ----------------
    portBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("fill%0d_ready", i), 64'(inReady), 64'(1));
      push_stalled(3'(i), 32'h100 + 32'(i));
    end
    check_val("fill_count", 64'(count), 64'(4));
    check_val("fill_ready", 64'(inReady), 64'(0));
    check_val("fill_we", 64'(writeEnable), 64'(0));
    inValid = 1'b1; inAddr = 3'd4; inData = 32'h104;
    portBusy = 1'b0;
    cyc();                                  // pop reg0, push refused
    check_val("fillA_waddr", 64'(writeAddr), 64'(0));
    check_val("fillA_we", 64'(writeEnable), 64'(1));
    check_val("fillA_count", 64'(count), 64'(3));
    check_val("fillA_ready", 64'(inReady), 64'(1));
    cyc();                                  // pop reg1 and push reg4
    inValid = 1'b0;
    check_val("fillB_waddr", 64'(writeAddr), 64'(1));
    check_val("fillB_wdata", 64'(writeData), 64'h101);
    check_val("fillB_count", 64'(count), 64'(3));
    for (int i = 2; i <= 4; i++) begin
      cyc();
      check_val($sformatf("fill_w%0d_we", i), 64'(writeEnable), 64'(1));
      check_val($sformatf("fill_w%0d_addr", i), 64'(writeAddr), 64'(i));
      check_val($sformatf("fill_w%0d_data", i), 64'(writeData), 64'h100 + 64'(i));
    end
    cyc();
    check_val("fill_end_we", 64'(writeEnable), 64'(0));
    check_val("fill_end_count", 64'(count), 64'(0));

    // ---------------- forward priority ----------------
    portBusy = 1'b1;
    push_stalled(3'd2, 32'h11);
    push_stalled(3'd2, 32'h22);
    readAddrA = 3'd2; readAddrB = 3'd5;
    #1;
    check_val("fp_count", 64'(count), 64'(2));
    check_val("fp_hitA", 64'(fwdHitA), 64'(1));
    check_val("fp_dataA", 64'(fwdDataA), 64'h22);
    check_val("fp_hitB_miss", 64'(fwdHitB), 64'(0));
    check_val("fp_dataB_zero", 64'(fwdDataB), 64'(0));
    readAddrB = 3'd2;
    #1;
    check_val("fp_dataB", 64'(fwdDataB), 64'h22);
    portBusy = 1'b0;
    cyc();                                  // retire 0x11
    check_val("fp1_wdata", 64'(writeData), 64'h11);
    check_val("fp1_dataA", 64'(fwdDataA), 64'h22);
    cyc();                                  // retire 0x22
    check_val("fp2_wdata", 64'(writeData), 64'h22);
    check_val("fp2_hitA", 64'(fwdHitA), 64'(1));
    check_val("fp2_dataA", 64'(fwdDataA), 64'h22);
    cyc();
    check_val("fp3_hitA", 64'(fwdHitA), 64'(0));

    // ---------------- simultaneous push/pop ----------------
    readAddrA = 3'd0; readAddrB = 3'd0;
    for (int i = 1; i <= 16; i++) begin
      inValid = 1'b1; inAddr = 3'(i); inData = 32'(i);
      cyc();
      check_val($sformatf("str%0d_count", i), 64'(count), 64'(1));
      if (i == 1) begin
        check_val("str1_we", 64'(writeEnable), 64'(0));
      end else begin
        check_val($sformatf("str%0d_we", i), 64'(writeEnable), 64'(1));
        check_val($sformatf("str%0d_wdata", i), 64'(writeData), 64'(i - 1));
      end
    end
    inValid = 1'b0;
    cyc();
    check_val("str_last_wdata", 64'(writeData), 64'h10);
    check_val("str_last_count", 64'(count), 64'(0));
    cyc();
    check_val("str_done_we", 64'(writeEnable), 64'(0));

    // ---------------- flush ----------------
    portBusy = 1'b1;
    push_stalled(3'd1, 32'hAA);
    push_stalled(3'd2, 32'hBB);
    push_stalled(3'd3, 32'hCC);
    push_stalled(3'd4, 32'hDD);
    portBusy = 1'b0;
    cyc();
    check_val("fl_we", 64'(writeEnable), 64'(1));
    check_val("fl_waddr", 64'(writeAddr), 64'(1));
    check_val("fl_wdata", 64'(writeData), 64'hAA);
    check_val("fl_count", 64'(count), 64'(3));
    flush = 1'b1;
    inValid = 1'b1; inAddr = 3'd6; inData = 32'h66;   // must not be pushed
    cyc();
    flush = 1'b0; inValid = 1'b0;
    readAddrA = 3'd2;
    #1;
    check_val("fl_after_we", 64'(writeEnable), 64'(0));
    check_val("fl_after_count", 64'(count), 64'(0));
    check_val("fl_after_busy", 64'(busy), 64'(0));
    check_val("fl_after_hitA", 64'(fwdHitA), 64'(0));
    for (int i = 0; i < 2; i++) begin
      cyc();
      check_val($sformatf("fl_idle%0d_we", i), 64'(writeEnable), 64'(0));
    end

    // ---------------- async reset ----------------
    portBusy = 1'b1;
    push_stalled(3'd5, 32'h55);
    push_stalled(3'd6, 32'h66);
    push_stalled(3'd7, 32'h77);
    portBusy = 1'b0;
    cyc();
    readAddrA = 3'd6;
    #1;
    check_val("ar_pre_we", 64'(writeEnable), 64'(1));
    check_val("ar_pre_count", 64'(count), 64'(2));
    check_val("ar_pre_hitA", 64'(fwdHitA), 64'(1));
    #2 rst = 1'b1;                          // mid-cycle, no clock edge
    #1;
    check_val("ar_we", 64'(writeEnable), 64'(0));
    check_val("ar_count", 64'(count), 64'(0));
    check_val("ar_hitA", 64'(fwdHitA), 64'(0));
    check_val("ar_waddr", 64'(writeAddr), 64'(0));
    check_val("ar_inReady", 64'(inReady), 64'(0));
    check_val("ar_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_val("ar_rel_inReady", 64'(inReady), 64'(1));
    cyc();
    check_val("ar_rel_we", 64'(writeEnable), 64'(0));
    check_val("ar_rel_count", 64'(count), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
